// File: rtl/ts_qracc_accum_pkg.sv
// Shared types and helpers for the ts_qracc digital back end: comparator count,
// accumulator FSM states and a reference thermometer decoder.
package qracc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} accState;

  localparam int defAdcBits = 4;

  function automatic int compCount(input int adcBits);
    return (1 << adcBits) - 1;
  endfunction

  // Popcount minus half scale, so comparator bubbles still decode sensibly.
  function automatic logic signed [defAdcBits-1:0] therm_decode(
    input logic [compCount(defAdcBits)-1:0] therm
  );
    int pop;
    pop = 0;
    for (int i = 0; i < compCount(defAdcBits); i++) pop += int'(therm[i]);
    return defAdcBits'(pop - (1 << (defAdcBits - 1)));
  endfunction

endpackage

// File: rtl/ts_therm_popcount.sv
// Combinational popcount of one column's thermometer comparator outputs.
module ts_therm_popcount #(
  parameter int numInputs = 15,
  parameter int countBits = $clog2(numInputs + 1)
) (
  input  logic [numInputs-1:0] therm,
  output logic [countBits-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < numInputs; i++) count = count + countBits'(therm[i]);
  end

endmodule

// File: rtl/ts_qracc_accum.sv
// Per-column shift-accumulator behind the ts_qracc macro: decodes one bit plane
// per accepted cycle, LSB first, and hands finished sums over valid/ready.
module ts_qracc_accum
  import qracc_pkg::*;
#(
  parameter int numCols    = 8,
  parameter int numAdcBits = 4,
  parameter int numInBits  = 4,
  parameter int accBits    = 16
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [compCount(numAdcBits)*numCols-1:0] ADC_IN,
  input  logic                                   SIGNED_ACT,
  input  logic                                   IN_VALID,
  output logic                                   IN_READY,
  input  logic                                   ABORT,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic [accBits*numCols-1:0]             OUT_DATA,
  output logic                                   BUSY
);

  localparam int numComps  = compCount(numAdcBits);
  localparam int popBits   = $clog2(numComps + 1);
  localparam int halfScale = 1 << (numAdcBits - 1);
  localparam int cntBits   = (numInBits > 1) ? $clog2(numInBits) : 1;
  localparam logic [cntBits-1:0] lastPlane = cntBits'(numInBits - 1);

  if (accBits < numAdcBits + numInBits + 1) begin : gWidthCheck
    $error("ts_qracc_accum: accBits too narrow for numAdcBits+numInBits+1");
  end

  accState                    state;
  logic [cntBits-1:0]         plane;
  logic                       signMode;
  logic                       outValid;
  logic                       busy;
  logic signed [accBits-1:0]  acc  [numCols];
  logic signed [accBits-1:0]  term [numCols];
  logic [popBits-1:0]         pop  [numCols];
  logic                       accept;
  logic                       signEff;
  logic                       negate;

  for (genvar j = 0; j < numCols; j++) begin : gCol
    ts_therm_popcount #(
      .numInputs(numComps),
      .countBits(popBits)
    ) uPop (
      .therm(ADC_IN[j*numComps +: numComps]),
      .count(pop[j])
    );

    assign term[j] = $signed(accBits'(pop[j]) - accBits'(halfScale)) <<< plane;
    assign OUT_DATA[j*accBits +: accBits] = acc[j];
  end

  assign IN_READY  = (state != HOLD) && !ABORT;
  assign accept    = IN_VALID && IN_READY;
  // The first plane must see the live sign input since the latch updates on it.
  assign signEff   = (plane == '0) ? SIGNED_ACT : signMode;
  assign negate    = signEff && (plane == lastPlane);
  assign OUT_VALID = outValid;
  assign BUSY      = busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      plane    <= '0;
      signMode <= 1'b0;
      outValid <= 1'b0;
      busy     <= 1'b0;
      for (int j = 0; j < numCols; j++) acc[j] <= '0;
    end else begin
      if (accept) begin
        for (int j = 0; j < numCols; j++) begin
          if (plane == '0) acc[j] <= negate ? -term[j] : term[j];
          else             acc[j] <= negate ? acc[j] - term[j] : acc[j] + term[j];
        end
        if (plane == '0) signMode <= SIGNED_ACT;
      end

      case (state)
        IDLE, ACCUM: begin
          if (ABORT) begin
            state <= IDLE;
            plane <= '0;
            busy  <= 1'b0;
          end else if (accept) begin
            busy <= 1'b1;
            if (plane == lastPlane) begin
              state    <= HOLD;
              plane    <= '0;
              outValid <= 1'b1;
            end else begin
              state <= ACCUM;
              plane <= plane + cntBits'(1);
            end
          end
        end
        // A handshake and an abort both release the result; the handshake wins.
        HOLD: begin
          if (OUT_READY || ABORT) begin
            state    <= IDLE;
            outValid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          plane    <= '0;
          outValid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_qracc_accum.sv
// Directed self-checking bench for ts_qracc_accum at default parameters.
module tb_ts_qracc_accum;

  localparam int numCols  = 8;
  localparam int numComps = 15;
  localparam int accBits  = 16;

  logic                          CLK = 1'b0;
  logic                          RST;
  logic [numComps*numCols-1:0]   ADC_IN;
  logic                          SIGNED_ACT;
  logic                          IN_VALID;
  logic                          IN_READY;
  logic                          ABORT;
  logic                          OUT_VALID;
  logic                          OUT_READY;
  logic [accBits*numCols-1:0]    OUT_DATA;
  logic                          BUSY;

  int compareCount  = 0;
  int mismatchCount = 0;

  ts_qracc_accum dut (
    .CLK       (CLK),
    .RST       (RST),
    .ADC_IN    (ADC_IN),
    .SIGNED_ACT(SIGNED_ACT),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ABORT     (ABORT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [numComps-1:0] therm(input int pop);
    logic [numComps-1:0] t;
    t = '0;
    for (int i = 0; i < pop; i++) t[i] = 1'b1;
    return t;
  endfunction

  function automatic logic [numComps*numCols-1:0] allCols(input logic [numComps-1:0] c);
    logic [numComps*numCols-1:0] w;
    for (int j = 0; j < numCols; j++) w[j*numComps +: numComps] = c;
    return w;
  endfunction

  // Column 0 and column 1 get their own popcounts, the rest decode to zero.
  function automatic logic [numComps*numCols-1:0] mixPlane(input int pop0, input int pop1);
    logic [numComps*numCols-1:0] w;
    w = allCols(therm(8));
    w[0 +: numComps]        = therm(pop0);
    w[numComps +: numComps] = therm(pop1);
    return w;
  endfunction

  function automatic longint colVal(input int j);
    logic signed [accBits-1:0] v;
    v = OUT_DATA[j*accBits +: accBits];
    return longint'(v);
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after an edge, then advance past the next edge.
  task automatic applyStimulus(input logic [numComps*numCols-1:0] adc, input logic valid);
    ADC_IN   = adc;
    IN_VALID = valid;
    @(posedge CLK);
    #1;
  endtask

  int pops1 [4] = '{0, 8, 8, 0};

  initial begin
    RST = 1'b1; ADC_IN = '0; SIGNED_ACT = 1'b0; IN_VALID = 1'b0;
    ABORT = 1'b0; OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    applyStimulus('0, 1'b0);
    checkOutput("resetOutValid", OUT_VALID, 0);
    checkOutput("resetBusy", BUSY, 0);
    checkOutput("resetOutData", (OUT_DATA == '0) ? 1 : 0, 1);
    checkOutput("resetInReady", IN_READY, 1);

    $display("[TB] unsigned max");
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(allCols(therm(15)), 1'b1);
      checkOutput($sformatf("maxEarlyValid%0d", k), OUT_VALID, 0);
    end
    checkOutput("maxBusy", BUSY, 1);
    applyStimulus(allCols(therm(15)), 1'b1);
    checkOutput("maxValid", OUT_VALID, 1);
    checkOutput("maxCol0", colVal(0), 105);
    checkOutput("maxCol7", colVal(7), 105);
    applyStimulus('0, 1'b0);
    checkOutput("maxValidDrop", OUT_VALID, 0);
    checkOutput("maxBusyDrop", BUSY, 0);

    $display("[TB] signed mixed");
    SIGNED_ACT = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mixPlane(15, pops1[k]), 1'b1);
      if (k == 0) SIGNED_ACT = 1'b0;
    end
    checkOutput("signedValid", OUT_VALID, 1);
    checkOutput("signedCol0", colVal(0), -7);
    checkOutput("signedCol1", colVal(1), 56);
    checkOutput("signedCol2", colVal(2), 0);
    applyStimulus('0, 1'b0);

    $display("[TB] bubble tolerance");
    SIGNED_ACT = 1'b0;
    applyStimulus(allCols(15'b000_0000_0101_1111), 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(allCols(therm(8)), 1'b1);
    checkOutput("bubbleValid", OUT_VALID, 1);
    checkOutput("bubbleCol0", colVal(0), -2);
    checkOutput("bubbleCol7", colVal(7), -2);
    applyStimulus('0, 1'b0);

    $display("[TB] backpressure");
    OUT_READY = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(allCols(therm(15)), 1'b1);
    checkOutput("bpValid", OUT_VALID, 1);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bpInReady%0d", c), IN_READY, 0);
      applyStimulus(allCols(therm(9)), 1'b1);
      checkOutput($sformatf("bpHoldValid%0d", c), OUT_VALID, 1);
      checkOutput($sformatf("bpHoldData%0d", c), colVal(0), 105);
    end
    OUT_READY = 1'b1;
    applyStimulus(allCols(therm(9)), 1'b1);
    checkOutput("bpReleaseValid", OUT_VALID, 0);
    checkOutput("bpReleaseReady", IN_READY, 1);
    for (int k = 0; k < 4; k++) applyStimulus(allCols(therm(9)), 1'b1);
    checkOutput("bpNextValid", OUT_VALID, 1);
    checkOutput("bpNextCol0", colVal(0), 15);
    applyStimulus('0, 1'b0);

    $display("[TB] abort in accumulate");
    for (int k = 0; k < 2; k++) applyStimulus(allCols(therm(0)), 1'b1);
    ABORT = 1'b1;
    ADC_IN = allCols(therm(0));
    IN_VALID = 1'b1;
    #1;
    checkOutput("abortInReady", IN_READY, 0);
    applyStimulus(allCols(therm(0)), 1'b1);
    checkOutput("abortBusy", BUSY, 0);
    checkOutput("abortValid", OUT_VALID, 0);
    ABORT = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(allCols(therm(15)), 1'b1);
    checkOutput("abortNextValid", OUT_VALID, 1);
    checkOutput("abortNextCol0", colVal(0), 105);
    applyStimulus('0, 1'b0);

    $display("[TB] abort in hold");
    OUT_READY = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(allCols(therm(9)), 1'b1);
    checkOutput("holdAbortPre", OUT_VALID, 1);
    ABORT = 1'b1;
    applyStimulus('0, 1'b0);
    checkOutput("holdAbortValid", OUT_VALID, 0);
    checkOutput("holdAbortBusy", BUSY, 0);
    ABORT = 1'b0;

    $display("[TB] reset in hold");
    for (int k = 0; k < 4; k++) applyStimulus(allCols(therm(15)), 1'b1);
    checkOutput("rstHoldPre", OUT_VALID, 1);
    RST = 1'b1;
    applyStimulus('0, 1'b0);
    checkOutput("rstHoldValid", OUT_VALID, 0);
    checkOutput("rstHoldBusy", BUSY, 0);
    checkOutput("rstHoldCol0", colVal(0), 0);
    RST = 1'b0;
    applyStimulus('0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
